gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

Self-checking stimulus/response sequencer for the two-input basic-gate blocks (AND, OR, XOR, NAND, NOR, XNOR on f0..f5). On a start pulse it walks the four input combinations of a/b, drives them to the gate block and waits a programmable settle time. It then samples the six function outputs, compares them against the built-in truth table and reports a per-function mismatch mask and an error count. It sits directly upstream and downstream of the gate block: its a/b outputs feed the gate inputs and it consumes f0..f5.

## Interface
- SETTLE, 2: cycles from an a/b update to the f sample; legal range 1..15.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  one-cycle request to run a check; honoured only in IDLE or DONE.
- abort  in  1  cancels a run in progress; returns to IDLE without setting done.
- f  in  6  gate outputs sampled from the DUT, f[0]=and, f[1]=or, f[2]=xor, f[3]=nand, f[4]=nor, f[5]=xnor.
- a  out  1  registered stimulus, equal to vec[1].
- b  out  1  registered stimulus, equal to vec[0].
- vec  out  2  index of the current input combination.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start, abort or reset.
- pass  out  1  done & (fail_mask == 0).
- fail_mask  out  6  sticky OR of per-bit mismatches across all vectors of the run.
- err_count  out  3  number of vectors (0..4) with at least one mismatching bit.

## Operation
- States: IDLE, RUN, DONE.
- Reset or abort sets state=IDLE, a=b=0, vec=0, busy=0, done=0, fail_mask=0, err_count=0, cnt=0.
- IDLE/DONE with start=1: state=RUN, vec=0, a=0, b=0, cnt=0, fail_mask=0, err_count=0, busy=1, done=0.
- RUN, cnt < SETTLE-1: cnt increments.
- RUN, cnt == SETTLE-1 (sample edge): mism = f ^ EXP[vec]; fail_mask |= mism; err_count += (mism != 0).
  - If vec < 3: vec increments, a/b follow the new vec, cnt=0.
  - If vec == 3: state=DONE, busy=0, done=1.
- Expected table, f[5:0] per vec (a,b): 00 -> 6'h38, 01 -> 6'h0E, 10 -> 6'h0E, 11 -> 6'h23.
- start while RUN is ignored.
- abort has priority over start in the same cycle.
- reset has priority over everything.
- DONE holds all results until start, abort or reset.
- err_count saturates at 4 by construction; no wrap.

## Timing
- start sampled at edge E0.
- Vector k drives a/b from edge E0+k*SETTLE.
- f for vector k is sampled at edge E0+(k+1)*SETTLE.
- done rises at edge E0+4*SETTLE; for SETTLE=2, that is 8 cycles after the start edge.
- With SETTLE=1, f is sampled one edge after a/b change; the DUT path must be purely combinational.
- fail_mask and err_count update at each sample edge, so partial results are visible during RUN.
- All outputs are registered; no combinational path from f or start to any output.

## Test plan
- Correct DUT (basic-gate model), SETTLE=2, start pulse -> a/b sequence 00,01,10,11 at 2-cycle spacing; done=1 at E0+8; pass=1, fail_mask=0, err_count=0.
- f[2] stuck at 0 -> vecs 01 and 10 mismatch; fail_mask=6'h04, err_count=2, pass=0.
- f forced to 6'h00 -> fail_mask=6'h3F, err_count=4, pass=0.
- abort asserted at E0+3 -> next edge IDLE, busy=0, done=0, results cleared; later start runs a clean pass.
- reset at E0+5 mid-run -> all outputs 0 next edge; start during RUN ignored, and done still rises at E0+8 with an unchanged sequence.
- Restart from DONE after a failing run with a correct DUT -> previous results cleared at the start edge; pass=1.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Truth-table sequencer for a two-input basic-gate block: walks a/b through 00..11,
// samples f[5:0] after SETTLE cycles per vector, and accumulates mismatch results.
module gate_truth_table_checker #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [5:0] f,
   output logic       a,
   output logic       b,
   output logic [1:0] vec,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] fail_mask,
   output logic [2:0] err_count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] LAST = 4'(SETTLE - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [5:0] mism;

   // f[5:0] = {xnor, nor, nand, xor, or, and} for inputs (a,b) = vec
   function automatic logic [5:0] exp_f(input logic [1:0] v);
      case (v)
         2'b00:   exp_f = 6'h38;
         2'b01:   exp_f = 6'h0E;
         2'b10:   exp_f = 6'h0E;
         default: exp_f = 6'h23;
      endcase
   endfunction

   always_comb begin
      mism = f ^ exp_f(vec);
   end

   always_ff @(posedge clk) begin
      if (reset || abort) begin
         state     <= IDLE;
         a         <= 1'b0;
         b         <= 1'b0;
         vec       <= 2'd0;
         cnt       <= 4'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= 6'h00;
         err_count <= 3'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  a         <= 1'b0;
                  b         <= 1'b0;
                  vec       <= 2'd0;
                  cnt       <= 4'd0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_mask <= 6'h00;
                  err_count <= 3'd0;
               end
            end
            RUN: begin
               if (cnt != LAST) begin
                  cnt <= cnt + 4'd1;
               end else begin
                  // sample edge: partial results become visible immediately
                  fail_mask <= fail_mask | mism;
                  err_count <= err_count + {2'b00, |mism};
                  if (vec != 2'd3) begin
                     vec    <= vec + 2'd1;
                     {a, b} <= vec + 2'd1;
                     cnt    <= 4'd0;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= ~|(fail_mask | mism);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: a gate model with injectable faults feeds f,
// stimulus pushes expected run results, a monitor checks them when done rises.
module tb_gate_truth_table_checker;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [5:0] f;
   logic       a, b, busy, done, pass;
   logic [1:0] vec;
   logic [5:0] fail_mask;
   logic [2:0] err_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int mode = 0;

   typedef struct {
      logic [5:0] fm;
      logic [2:0] ec;
      logic       ps;
      int         c0;
   } exp_t;

   exp_t sb[$];

   gate_truth_table_checker #(.SETTLE(SETTLE)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .f(f),
      .a(a), .b(b), .vec(vec), .busy(busy), .done(done), .pass(pass),
      .fail_mask(fail_mask), .err_count(err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // gate block model; modes 1..3 inject faults
   always_comb begin
      f = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
      case (mode)
         1:       f[2] = 1'b0;
         2:       f = 6'h00;
         3:       f[0] = 1'b1;
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops on every rising edge of done
   logic done_q = 1'b0;
   always @(negedge clk) begin
      if (done && !done_q) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.c0 + 4 * SETTLE);
            chk("fail_mask", {26'd0, fail_mask}, {26'd0, e.fm});
            chk("err_count", {29'd0, err_count}, {29'd0, e.ec});
            chk("pass", {31'd0, pass}, {31'd0, e.ps});
         end
      end
      done_q <= done;
   end

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_pass"}, {31'd0, pass}, 0);
      chk({tag, "_vec_ab"}, {28'd0, vec, a, b}, 0);
      chk({tag, "_fm"}, {26'd0, fail_mask}, 0);
      chk({tag, "_ec"}, {29'd0, err_count}, 0);
   endtask

   // Full run; optionally pulses start mid-run (must be ignored)
   task automatic run_check(input int m, input logic [5:0] efm, input logic [2:0] eec,
                            input bit mid_start);
      exp_t e;
      int   k;
      @(negedge clk);
      mode = m;
      e.fm = efm; e.ec = eec; e.ps = (efm == 6'h00); e.c0 = cyc + 1;
      sb.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (m == 0 && !mid_start)
         chk("start_clears", {27'd0, busy, fail_mask[2:0], err_count[0]}, 32'h10);
      for (int j = 0; j < 4 * SETTLE; j++) begin
         k = j / SETTLE;
         chk("vec_seq", {30'd0, vec}, k[31:0]);
         chk("ab_seq", {30'd0, a, b}, k[31:0]);
         chk("busy_run", {31'd0, busy}, 1);
         start = (mid_start && j == 2) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", {31'd0, done}, 1);
      repeat (3) @(negedge clk);
      chk("done_hold", {31'd0, done}, 1);
      chk("busy_done", {31'd0, busy}, 0);
      chk("fm_hold", {26'd0, fail_mask}, {26'd0, efm});
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_idle("reset");

      run_check(0, 6'h00, 3'd0, 1'b0);
      run_check(1, 6'h04, 3'd2, 1'b0);
      run_check(0, 6'h00, 3'd0, 1'b0);   // restart from DONE after failure
      run_check(2, 6'h3F, 3'd4, 1'b0);
      run_check(3, 6'h01, 3'd3, 1'b0);

      // abort at E0+3 with partial results present
      @(negedge clk);
      mode = 2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("partial_fm", {26'd0, fail_mask}, 32'h38);
      chk("partial_ec", {29'd0, err_count}, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_idle("abort");
      repeat (10) @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 0);
      run_check(0, 6'h00, 3'd0, 1'b0);

      // abort beats start in the same cycle
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk_idle("abort_prio");

      // reset at E0+5 mid-run, then a run with a start pulse during RUN
      @(negedge clk);
      mode = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_idle("midreset");
      run_check(0, 6'h00, 3'd0, 1'b1);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
